// File: rtl/ir_seq_pkg.sv
// ir_seq_pkg: shared state encoding and constants for the 6502 IR fetch sequencer.
package ir_seq_pkg;
  localparam logic [1:0] ST_RST = 2'd0;
  localparam logic [1:0] ST_FET = 2'd1;
  localparam logic [1:0] ST_EXE = 2'd2;
  localparam logic [7:0] BRK_OPC = 8'h00;
  localparam int RST_CYCLES_DEF = 6;
endpackage

// File: rtl/ir_seq_tcnt.sv
// ir_seq_tcnt: T-cycle counter, also reused as the post-reset sequence counter.
module ir_seq_tcnt #(
  parameter int W = 3,
  parameter int RST_CYCLES = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         ld1_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_rst_o,
  output logic         tc_max_o
);
  // wide enough for both the T-count and the last reset-sequence value
  localparam int CW = (W > $clog2(RST_CYCLES)) ? W : $clog2(RST_CYCLES);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << W) - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : ld1_i ? CW'(1) : en_i ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q[W-1:0];
  assign tc_rst_o = cnt_q == RST_LAST;
  assign tc_max_o = cnt_q == CNT_MAX;
endmodule

// File: rtl/ir_fetch_seq.sv
// ir_fetch_seq: FETCH/SYNC and T-state sequencer for the 6502 IR with opcode latch.
// Define IR_SEQ_INT_EN to enable BRK injection on IRQ_PEND at fetch.
module ir_fetch_seq
  import ir_seq_pkg::*;
#(
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int TCNT_W = 3
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              RDY,
  input  logic [7:0]        n_PD,
  input  logic              TRES,
  input  logic              IRQ_PEND,
  output logic              FETCH,
  output logic              SYNC,
  output logic [TCNT_W-1:0] TCNT,
  output logic [7:0]        OPC,
  output logic              OPC_VALID,
  output logic              INJ,
  output logic              IRQ_ACK,
  output logic              HANG
);
  logic [1:0] state_q, state_d;
  logic [7:0] opc_q, opc_d;
  logic inj_q, inj_d, ack_q, ack_d, hang_q, hang_d;
  logic irq, in_rst, cap, exe_go, cnt_clr, cnt_en, tc_rst, tc_max;
  logic [TCNT_W-1:0] cnt;
`ifdef IR_SEQ_INT_EN
  assign irq = IRQ_PEND;
`else
  logic unused_irq;
  assign unused_irq = IRQ_PEND;
  assign irq = 1'b0;
`endif
  always_comb begin
    in_rst = state_q == ST_RST;
    cap = (state_q == ST_FET) && RDY;
    exe_go = (state_q == ST_EXE) && RDY;
    cnt_clr = (in_rst && tc_rst) || (exe_go && (TRES || tc_max));
    cnt_en = in_rst || (exe_go && !TRES);
    state_d = (in_rst && tc_rst) ? ST_FET : cap ? ST_EXE : (exe_go && (TRES || tc_max)) ? ST_FET : state_q;
    opc_d = cap ? (irq ? BRK_OPC : ~n_PD) : opc_q;
    inj_d = cap ? irq : inj_q;
    ack_d = cap && irq;
    // overrunning TCNT_MAX without TRES forces the next fetch and latches HANG
    hang_d = hang_q || (exe_go && !TRES && tc_max);
  end
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= ST_RST;
      opc_q <= 8'h00;
      inj_q <= 1'b0;
      ack_q <= 1'b0;
      hang_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q <= opc_d;
      inj_q <= inj_d;
      ack_q <= ack_d;
      hang_q <= hang_d;
    end
  end
  ir_seq_tcnt #(.W(TCNT_W), .RST_CYCLES(RST_CYCLES)) u_tcnt (
    .clk_i(CLK),
    .rst_i(RES),
    .en_i(cnt_en),
    .clr_i(cnt_clr),
    .ld1_i(cap),
    .cnt_o(cnt),
    .tc_rst_o(tc_rst),
    .tc_max_o(tc_max)
  );
  assign FETCH = state_q == ST_FET;
  assign SYNC = FETCH;
  assign TCNT = in_rst ? '0 : cnt;
  assign OPC = opc_q;
  assign OPC_VALID = state_q == ST_EXE;
  assign INJ = inj_q;
  assign IRQ_ACK = ack_q;
  assign HANG = hang_q;
endmodule
